// File: rtl/phy_mgmt_pkg.sv
// Shared constants and state types for the PHY management sequencer and its
// MDIO transaction engine.
package phy_mgmt_pkg;

  localparam logic [4:0] REG_BMCR   = 5'd0;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_ANAR   = 5'd4;
  localparam logic [4:0] REG_ANLPAR = 5'd5;

  localparam logic [15:0] BMCR_SOFT_RST   = 16'h8000;
  localparam logic [15:0] BMCR_AN_RESTART = 16'h1200;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_RST,
    S_POLL_RST,
    S_WR_ANAR,
    S_WR_BMCR,
    S_WAIT_POLL,
    S_RD_BMSR,
    S_RD_ANLPAR,
    S_ERROR
  } main_state_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_WAIT_FREE,
    X_START,
    X_WAIT_DONE
  } xact_state_e;

  // Controller command word: {phy address, register address, op}.
  function automatic logic [10:0] pack_addr_mode(input logic [4:0] phy,
                                                 input logic [4:0] reg_addr,
                                                 input logic       op);
    return {phy, reg_addr, op};
  endfunction

  function automatic logic is_xact_state(input main_state_e s);
    return s inside {S_WR_RST, S_POLL_RST, S_WR_ANAR, S_WR_BMCR, S_RD_BMSR, S_RD_ANLPAR};
  endfunction

endpackage

// File: rtl/phy_mgmt_sequencer_xact.sv
// MDIO transaction engine: one register transaction at a time against the
// controller's start/busy handshake, with a per-wait-state timeout.
module mdio_xact
  import phy_mgmt_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [10:0] addr_mode_i,
  input  logic [15:0] wdata_i,
  output logic        mdio_start_o,
  output logic [10:0] mdio_addr_mode_o,
  output logic [15:0] mdio_data_o,
  input  logic [15:0] mdio_data_i,
  input  logic        mdio_busy_i,
  output logic        done_o,
  output logic        timeout_o,
  output logic [15:0] rdata_o
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  xact_state_e   state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [10:0]   addr_mode_q, addr_mode_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1));

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q + 1'b1;
    addr_mode_d = addr_mode_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      X_IDLE: begin
        if (req_i) begin
          addr_mode_d = addr_mode_i;
          wdata_d     = wdata_i;
          state_d     = X_WAIT_FREE;
        end
      end
      X_WAIT_FREE: begin
        if (!mdio_busy_i) begin
          state_d = X_START;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = X_IDLE;
        end
      end
      X_START: begin
        if (mdio_busy_i) begin
          state_d = X_WAIT_DONE;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = X_IDLE;
        end
      end
      X_WAIT_DONE: begin
        if (!mdio_busy_i) begin
          if (addr_mode_q[0] == OP_READ) rdata_d = mdio_data_i;
          done_d  = 1'b1;
          state_d = X_IDLE;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = X_IDLE;
        end
      end
      default: state_d = X_IDLE;
    endcase

    // The timeout measures time spent in the current state only.
    if (state_d != state_q || state_q == X_IDLE) tmo_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= X_IDLE;
      tmo_cnt_q   <= '0;
      addr_mode_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      addr_mode_q <= addr_mode_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mdio_start_o     = (state_q == X_START);
  assign mdio_addr_mode_o = addr_mode_q;
  assign mdio_data_o      = wdata_q;
  assign done_o           = done_q;
  assign timeout_o        = timeout_q;
  assign rdata_o          = rdata_q;

endmodule

// File: rtl/phy_mgmt_sequencer.sv
// PHY bring-up and link-status poller; issues register transactions through
// mdio_xact and publishes link_up/speed/duplex to the MAC.
module phy_mgmt_sequencer
  import phy_mgmt_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR      = 5'b01101,
  parameter logic [15:0] ANAR_VALUE    = 16'h01E1,
  parameter int          POLL_INTERVAL = 25_000_000,
  parameter int          RST_POLL_MAX  = 16,
  parameter int          BUSY_TIMEOUT  = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        restart_i,
  output logic        mdio_start_o,
  output logic [10:0] mdio_addr_mode_o,
  output logic [15:0] mdio_data_o,
  input  logic [15:0] mdio_data_i,
  input  logic        mdio_busy_i,
  output logic        init_done_o,
  output logic        link_up_o,
  output logic        speed_100_o,
  output logic        full_duplex_o,
  output logic        error_o
);

  localparam int         PW        = $clog2(POLL_INTERVAL + 1);
  localparam int         RW        = $clog2(RST_POLL_MAX + 1);
  localparam logic [2:0] ANAR_ABIL = ANAR_VALUE[8:6];

  main_state_e   state_q, state_d;
  logic          req_sent_q, req_sent_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          restart_pend_q, restart_pend_d;
  logic          init_done_q, init_done_d;
  logic          link_up_q, link_up_d;
  logic          speed_q, speed_d;
  logic          duplex_q, duplex_d;
  logic          error_q, error_d;

  logic          xact_req, xact_done, xact_timeout;
  logic [15:0]   xact_rdata;
  logic [4:0]    txn_reg;
  logic          txn_op;
  logic [15:0]   txn_wdata;
  logic [2:0]    ability;
  logic          go_idle, go_restart, go_error;
  logic          rdata_unused;

  assign ability      = xact_rdata[8:6] & ANAR_ABIL;
  assign rdata_unused = ^{xact_rdata[14:9], xact_rdata[5:3], xact_rdata[1:0]};

  // A new transaction is only launched when nothing is in flight and no
  // pending enable-drop or restart would abandon it.
  assign xact_req = is_xact_state(state_q) && !req_sent_q && enable_i && !restart_pend_q;

  always_comb begin
    txn_reg   = REG_BMCR;
    txn_op    = OP_READ;
    txn_wdata = '0;
    unique case (state_q)
      S_WR_RST:    begin txn_op = OP_WRITE; txn_wdata = BMCR_SOFT_RST; end
      S_POLL_RST:  txn_reg = REG_BMCR;
      S_WR_ANAR:   begin txn_reg = REG_ANAR; txn_op = OP_WRITE; txn_wdata = ANAR_VALUE; end
      S_WR_BMCR:   begin txn_op = OP_WRITE; txn_wdata = BMCR_AN_RESTART; end
      S_RD_BMSR:   txn_reg = REG_BMSR;
      S_RD_ANLPAR: txn_reg = REG_ANLPAR;
      default:     txn_reg = REG_BMCR;
    endcase
  end

  mdio_xact #(
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) u_xact (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_i            (xact_req),
    .addr_mode_i      (pack_addr_mode(PHY_ADDR, txn_reg, txn_op)),
    .wdata_i          (txn_wdata),
    .mdio_start_o     (mdio_start_o),
    .mdio_addr_mode_o (mdio_addr_mode_o),
    .mdio_data_o      (mdio_data_o),
    .mdio_data_i      (mdio_data_i),
    .mdio_busy_i      (mdio_busy_i),
    .done_o           (xact_done),
    .timeout_o        (xact_timeout),
    .rdata_o          (xact_rdata)
  );

  always_comb begin
    state_d        = state_q;
    req_sent_d     = req_sent_q;
    rst_cnt_d      = rst_cnt_q;
    poll_cnt_d     = poll_cnt_q;
    init_done_d    = init_done_q;
    link_up_d      = link_up_q;
    speed_d        = speed_q;
    duplex_d       = duplex_q;
    error_d        = error_q;
    restart_pend_d = (state_q != S_IDLE) && (state_q != S_ERROR) && (restart_pend_q || restart_i);
    go_idle        = 1'b0;
    go_restart     = 1'b0;
    go_error       = 1'b0;

    if (xact_req) req_sent_d = 1'b1;
    if (xact_done || xact_timeout) req_sent_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d   = S_WR_RST;
          rst_cnt_d = '0;
        end
      end
      S_ERROR: begin
        if (!enable_i) go_idle = 1'b1;
      end
      S_WAIT_POLL: begin
        if (!enable_i) begin
          go_idle = 1'b1;
        end else if (restart_pend_q) begin
          go_restart = 1'b1;
        end else if (poll_cnt_q == PW'(POLL_INTERVAL - 1)) begin
          state_d    = S_RD_BMSR;
          poll_cnt_d = '0;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      default: begin
        // Transaction states: decisions are taken only at a transaction
        // boundary, i.e. on completion or before the request goes out.
        if (xact_timeout) begin
          go_error = 1'b1;
        end else if (xact_done || !req_sent_q) begin
          if (!enable_i) begin
            go_idle = 1'b1;
          end else if (restart_pend_q) begin
            go_restart = 1'b1;
          end else if (xact_done) begin
            unique case (state_q)
              S_WR_RST: begin
                state_d   = S_POLL_RST;
                rst_cnt_d = '0;
              end
              S_POLL_RST: begin
                if (!xact_rdata[15])                           state_d   = S_WR_ANAR;
                else if (rst_cnt_q == RW'(RST_POLL_MAX - 1))   go_error  = 1'b1;
                else                                           rst_cnt_d = rst_cnt_q + 1'b1;
              end
              S_WR_ANAR: state_d = S_WR_BMCR;
              S_WR_BMCR: begin
                init_done_d = 1'b1;
                poll_cnt_d  = '0;
                state_d     = S_WAIT_POLL;
              end
              S_RD_BMSR: begin
                link_up_d = xact_rdata[2];
                if (xact_rdata[2]) begin
                  state_d = S_RD_ANLPAR;
                end else begin
                  speed_d    = 1'b0;
                  duplex_d   = 1'b0;
                  poll_cnt_d = '0;
                  state_d    = S_WAIT_POLL;
                end
              end
              S_RD_ANLPAR: begin
                // Highest common ability wins: 100FD, 100HD, 10FD, else 10HD.
                speed_d    = ability[2] | ability[1];
                duplex_d   = ability[2] | (!ability[1] & ability[0]);
                poll_cnt_d = '0;
                state_d    = S_WAIT_POLL;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase

    if (go_error) begin
      state_d        = S_ERROR;
      error_d        = 1'b1;
      init_done_d    = 1'b0;
      link_up_d      = 1'b0;
      speed_d        = 1'b0;
      duplex_d       = 1'b0;
      restart_pend_d = 1'b0;
    end
    if (go_idle) begin
      state_d        = S_IDLE;
      error_d        = 1'b0;
      init_done_d    = 1'b0;
      link_up_d      = 1'b0;
      speed_d        = 1'b0;
      duplex_d       = 1'b0;
      restart_pend_d = 1'b0;
    end
    if (go_restart) begin
      state_d        = S_WR_RST;
      init_done_d    = 1'b0;
      rst_cnt_d      = '0;
      restart_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      req_sent_q     <= 1'b0;
      rst_cnt_q      <= '0;
      poll_cnt_q     <= '0;
      restart_pend_q <= 1'b0;
      init_done_q    <= 1'b0;
      link_up_q      <= 1'b0;
      speed_q        <= 1'b0;
      duplex_q       <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_sent_q     <= req_sent_d;
      rst_cnt_q      <= rst_cnt_d;
      poll_cnt_q     <= poll_cnt_d;
      restart_pend_q <= restart_pend_d;
      init_done_q    <= init_done_d;
      link_up_q      <= link_up_d;
      speed_q        <= speed_d;
      duplex_q       <= duplex_d;
      error_q        <= error_d;
    end
  end

  assign init_done_o   = init_done_q;
  assign link_up_o     = link_up_q;
  assign speed_100_o   = speed_q;
  assign full_duplex_o = duplex_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_phy_mgmt_sequencer.sv
// Scoreboard bench for phy_mgmt_sequencer: a behavioural MDIO controller
// model answers transactions while a monitor checks each issued command.
module tb_phy_mgmt_sequencer;
  import phy_mgmt_pkg::*;

  localparam logic [4:0] PHY = 5'b01101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  logic        restart_i = 1'b0;
  logic        mdio_start_o;
  logic [10:0] mdio_addr_mode_o;
  logic [15:0] mdio_data_o;
  logic [15:0] mdio_rdata = '0;
  logic        mdio_busy = 1'b0;
  logic        init_done_o, link_up_o, speed_100_o, full_duplex_o, error_o;

  always #20 clk = ~clk;

  phy_mgmt_sequencer #(
    .POLL_INTERVAL(200)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_i         (enable_i),
    .restart_i        (restart_i),
    .mdio_start_o     (mdio_start_o),
    .mdio_addr_mode_o (mdio_addr_mode_o),
    .mdio_data_o      (mdio_data_o),
    .mdio_data_i      (mdio_rdata),
    .mdio_busy_i      (mdio_busy),
    .init_done_o      (init_done_o),
    .link_up_o        (link_up_o),
    .speed_100_o      (speed_100_o),
    .full_duplex_o    (full_duplex_o),
    .error_o          (error_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- controller model ----------------
  logic [15:0] bmsr_val = '0;
  logic [15:0] anlpar_val = '0;
  bit          stuck = 1'b0;
  bit          no_busy = 1'b0;
  int          done_cnt = 0;

  initial begin : model
    int          phase;
    int          mcnt;
    int          rd0_cnt;
    logic [15:0] bmcr;
    logic [10:0] m_am;
    logic [15:0] m_d;
    phase = 0; mcnt = 0; rd0_cnt = 0; bmcr = '0; m_am = '0; m_d = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mdio_busy <= 1'b0;
        phase = 0;
        mcnt  = 0;
      end else begin
        case (phase)
          0: if (mdio_start_o && !no_busy) begin
               phase = 1; mcnt = 0; m_am = mdio_addr_mode_o; m_d = mdio_data_o;
             end
          1: if (mcnt == 1) begin
               mdio_busy <= 1'b1; phase = 2; mcnt = 0;
             end else mcnt++;
          default: if (mcnt == 63) begin
               mdio_busy <= 1'b0;
               phase = 0;
               if (m_am[0]) begin
                 if (m_am[5:1] == REG_BMCR) begin bmcr = m_d; rd0_cnt = 0; end
               end else begin
                 case (m_am[5:1])
                   REG_BMCR: begin
                     rd0_cnt++;
                     if (!stuck && rd0_cnt >= 3) bmcr[15] = 1'b0;
                     mdio_rdata <= bmcr;
                   end
                   REG_BMSR:   mdio_rdata <= bmsr_val;
                   REG_ANLPAR: mdio_rdata <= anlpar_val;
                   default:    mdio_rdata <= 16'h0000;
                 endcase
               end
               done_cnt++;
             end else mcnt++;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [10:0] am;
    logic [15:0] d;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input logic [4:0] r, input logic op, input logic [15:0] dd);
    exp_t e;
    e.am = {PHY, r, op};
    e.d  = dd;
    exp_q.push_back(e);
  endtask

  task automatic push_bringup();
    push(REG_BMCR, OP_WRITE, 16'h8000);
    for (int i = 0; i < 3; i++) push(REG_BMCR, OP_READ, 16'h0000);
    push(REG_ANAR, OP_WRITE, 16'h01E1);
    push(REG_BMCR, OP_WRITE, 16'h1200);
  endtask

  initial begin : monitor
    logic start_prev;
    exp_t e;
    start_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mdio_start_o && !start_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xact: got addr_mode %0h data %0h, none expected at %0t",
                   mdio_addr_mode_o, mdio_data_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("xact_addr_mode", 32'(mdio_addr_mode_o), 32'(e.am));
          if (e.am[0]) check("xact_wdata", 32'(mdio_data_o), 32'(e.d));
        end
      end
      start_prev = mdio_start_o;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic cond(input int which);
    case (which)
      0:       return init_done_o;
      1:       return error_o;
      default: return mdio_busy;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget && !cond(which)) begin
      @(negedge clk);
      cycles++;
    end
    check(name, 32'(cond(which)), 32'd1);
  endtask

  task automatic wait_xacts(input string name, input int n, input int budget);
    int target;
    int i;
    target = done_cnt + n;
    for (i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    check(name, 32'(done_cnt >= target), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_link(input string tag, input logic lu, input logic sp, input logic fd);
    check({tag, "_link_up"}, 32'(link_up_o), 32'(lu));
    check({tag, "_speed_100"}, 32'(speed_100_o), 32'(sp));
    check({tag, "_full_duplex"}, 32'(full_duplex_o), 32'(fd));
  endtask

  initial begin : watchdog
    #10ms;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    repeat (3) @(negedge clk);
    check("rst_init_done", 32'(init_done_o), 0);
    check("rst_error", 32'(error_o), 0);
    check("rst_start", 32'(mdio_start_o), 0);
    check("rst_addr_mode", 32'(mdio_addr_mode_o), 0);
    check_link("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal bring-up, then first poll resolves 100 FD.
    bmsr_val = 16'h0004;
    anlpar_val = 16'h0181;
    push_bringup();
    push(REG_BMSR, OP_READ, 16'h0000);
    push(REG_ANLPAR, OP_READ, 16'h0000);
    enable_i = 1'b1;
    wait_for("bringup_init_done", 0, 2000, cyc);
    check("bringup_link_before_poll", 32'(link_up_o), 0);
    check("bringup_pending_polls", exp_q.size(), 2);
    wait_xacts("poll1_done", 2, 800);
    check_link("poll_100fd", 1'b1, 1'b1, 1'b1);

    // Partner offers only 10 HD.
    anlpar_val = 16'h0021;
    push(REG_BMSR, OP_READ, 16'h0000);
    push(REG_ANLPAR, OP_READ, 16'h0000);
    wait_xacts("poll2_done", 2, 800);
    check_link("poll_10hd", 1'b1, 1'b0, 1'b0);

    // Link down: no ANLPAR read, speed/duplex cleared.
    bmsr_val = 16'h0000;
    push(REG_BMSR, OP_READ, 16'h0000);
    wait_xacts("poll3_done", 1, 800);
    check_link("poll_down", 1'b0, 1'b0, 1'b0);
    check("poll_down_init_done", 32'(init_done_o), 1);

    // Restart while waiting between polls reruns bring-up from soft reset.
    bmsr_val = 16'h0004;
    anlpar_val = 16'h0181;
    push_bringup();
    push(REG_BMSR, OP_READ, 16'h0000);
    push(REG_ANLPAR, OP_READ, 16'h0000);
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    repeat (2) @(negedge clk);
    check("restart_clears_init", 32'(init_done_o), 0);
    wait_for("restart_init_done", 0, 2000, cyc);
    wait_xacts("restart_polls_done", 2, 800);
    check_link("restart_100fd", 1'b1, 1'b1, 1'b1);

    // rst_n pulsed mid-transaction: outputs drop immediately.
    push(REG_BMSR, OP_READ, 16'h0000);
    wait_for("rst_mid_busy", 2, 400, cyc);
    rst_n = 1'b0;
    #1;
    check("rstmid_init_done", 32'(init_done_o), 0);
    check("rstmid_start", 32'(mdio_start_o), 0);
    check_link("rstmid", 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    push_bringup();
    push(REG_BMSR, OP_READ, 16'h0000);
    push(REG_ANLPAR, OP_READ, 16'h0000);
    rst_n = 1'b1;
    wait_for("rstmid_reinit", 0, 2000, cyc);
    wait_xacts("rstmid_polls_done", 2, 800);
    check_link("rstmid_relink", 1'b1, 1'b1, 1'b1);

    // enable_i drops while the ANLPAR read is on the wire.
    push(REG_BMSR, OP_READ, 16'h0000);
    push(REG_ANLPAR, OP_READ, 16'h0000);
    wait_xacts("drop_bmsr_done", 1, 800);
    wait_for("drop_anlpar_busy", 2, 100, cyc);
    enable_i = 1'b0;
    @(negedge clk);
    check("drop_link_held", 32'(link_up_o), 1);
    wait_xacts("drop_anlpar_done", 1, 200);
    check("drop_init_done", 32'(init_done_o), 0);
    check("drop_error", 32'(error_o), 0);
    check_link("drop", 1'b0, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    check("drop_no_start", 32'(mdio_start_o), 0);
    check("drop_queue_empty", exp_q.size(), 0);

    // BMCR reset bit never clears: exactly 16 reads then error.
    stuck = 1'b1;
    push(REG_BMCR, OP_WRITE, 16'h8000);
    for (int i = 0; i < 16; i++) push(REG_BMCR, OP_READ, 16'h0000);
    enable_i = 1'b1;
    wait_for("stuck_error", 1, 3000, cyc);
    check("stuck_init_done", 32'(init_done_o), 0);
    repeat (200) @(negedge clk);
    check("stuck_reads_consumed", exp_q.size(), 0);
    check("stuck_start", 32'(mdio_start_o), 0);
    enable_i = 1'b0;
    repeat (2) @(negedge clk);
    check("stuck_error_cleared", 32'(error_o), 0);
    stuck = 1'b0;

    // Controller never goes busy: start times out after BUSY_TIMEOUT cycles.
    no_busy = 1'b1;
    push(REG_BMCR, OP_WRITE, 16'h8000);
    enable_i = 1'b1;
    wait_for("tmo_error", 1, 2300, cyc);
    check("tmo_latency_window", 32'(cyc >= 2048 && cyc <= 2070), 1);
    check("tmo_start_low", 32'(mdio_start_o), 0);
    check("tmo_init_done", 32'(init_done_o), 0);
    enable_i = 1'b0;
    repeat (2) @(negedge clk);
    check("tmo_error_cleared", 32'(error_o), 0);
    no_busy = 1'b0;

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
